// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU gatekeeper result path.
// Holds the common word-count type and the result packer state encoding.
package hs_npu_pkg;

  typedef logic [15:0] uword;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } packer_state_e;

endpackage

// File: rtl/hs_npu_beat_reg.sv
// Valid/ready output register for one packed beat.
// Payload, mask and last are frozen while the beat is stalled.
module hs_npu_beat_reg #(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk_core,
  input  logic                   rst_core_n,
  input  logic                   load,
  input  logic [LANES*WIDTH-1:0] load_data,
  input  logic [LANES-1:0]       load_mask,
  input  logic                   load_last,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       lane_mask,
  output logic                   last
);

  logic                   valid_r;
  logic [LANES*WIDTH-1:0] data_r;
  logic [LANES-1:0]       mask_r;
  logic                   last_r;

  // Beat register: load on publish, drop valid on handshake, otherwise hold
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      mask_r  <= '0;
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      mask_r  <= load_mask;
      last_r  <= load_last;
    end else if (ready_i) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid_o   = valid_r;
  assign out       = data_r;
  assign lane_mask = mask_r;
  assign last      = last_r;

endmodule

// File: rtl/hs_npu_result_packer.sv
// Drains the gatekeeper output FIFO and packs LANES words per writeback beat.
// Counts a programmed batch, flags the final beat and pulses done at the end.
module hs_npu_result_packer
  import hs_npu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 4
) (
  input  logic                   clk_core,
  input  logic                   rst_core_n,
  input  logic                   start,
  input  uword                   expected_words,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH-1:0]       in,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LANES*WIDTH-1:0] out,
  output logic [LANES-1:0]       lane_mask,
  output logic                   last,
  output logic                   busy,
  output logic                   done
);

  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int BEAT_W     = LANES * WIDTH;

  packer_state_e         state_r;
  packer_state_e         state_nx_s;
  uword                  remaining_r;
  logic [LANE_IDX_W-1:0] idx_r;
  logic [BEAT_W-1:0]     stage_data_r;
  logic [LANES-1:0]      stage_mask_r;
  logic                  busy_r;
  logic                  done_r;

  logic                  accept_s;
  logic                  final_word_s;
  logic                  publish_s;
  logic [BEAT_W-1:0]     merged_data_s;
  logic [LANES-1:0]      merged_mask_s;

  // A stalled beat blocks intake; otherwise the packer takes one word per cycle
  assign ready_o      = (state_r == COLLECT) && (!valid_o || ready_i);
  assign accept_s     = valid_i && ready_o;
  assign final_word_s = (remaining_r == uword'(1));
  assign publish_s    = accept_s && ((idx_r == LANE_IDX_W'(LANES - 1)) || final_word_s);

  // Staging buffer with the incoming word merged into the current lane
  always_comb begin
    merged_data_s = stage_data_r;
    merged_mask_s = stage_mask_r;
    for (int k = 0; k < LANES; k++) begin
      if (idx_r == LANE_IDX_W'(k)) begin
        merged_data_s[k*WIDTH +: WIDTH] = in;
        merged_mask_s[k]                = 1'b1;
      end else begin
        merged_data_s[k*WIDTH +: WIDTH] = stage_data_r[k*WIDTH +: WIDTH];
        merged_mask_s[k]                = stage_mask_r[k];
      end
    end
  end

  // Next-state logic for the batch sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = (expected_words == uword'(0)) ? DONE : COLLECT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      COLLECT: begin
        if (accept_s && final_word_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = COLLECT;
        end
      end
      DRAIN: begin
        if (valid_o && ready_i) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus registered busy/done derived from the next state
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == COLLECT) || (state_nx_s == DRAIN);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Word counter, lane index and staging bank; a publish restarts at lane 0
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      remaining_r  <= uword'(0);
      idx_r        <= '0;
      stage_data_r <= '0;
      stage_mask_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      remaining_r  <= expected_words;
      idx_r        <= '0;
      stage_data_r <= '0;
      stage_mask_r <= '0;
    end else if (accept_s) begin
      remaining_r <= remaining_r - uword'(1);
      if (publish_s) begin
        idx_r        <= '0;
        stage_data_r <= '0;
        stage_mask_r <= '0;
      end else begin
        idx_r        <= idx_r + LANE_IDX_W'(1);
        stage_data_r <= merged_data_s;
        stage_mask_r <= merged_mask_s;
      end
    end else begin
      remaining_r <= remaining_r;
    end
  end

  hs_npu_beat_reg #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_beat_reg (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .load       (publish_s),
    .load_data  (merged_data_s),
    .load_mask  (merged_mask_s),
    .load_last  (final_word_s),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .out        (out),
    .lane_mask  (lane_mask),
    .last       (last)
  );

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_hs_npu_result_packer.sv
// Directed bench for hs_npu_result_packer: full, partial, stalled, empty,
// ignored-start and mid-batch-reset batches against hand-computed beats.
module tb_hs_npu_result_packer;
  import hs_npu_pkg::*;

  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int BW    = WIDTH * LANES;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  logic          start = 1'b0;
  uword          expected_words = '0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b1;
  logic [31:0]   in_word = '0;
  logic          ready_o;
  logic          valid_o;
  logic [BW-1:0] out_beat;
  logic [3:0]    lane_mask;
  logic          last;
  logic          busy;
  logic          done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [BW-1:0] beat_data [64];
  logic [3:0]    beat_mask [64];
  logic          beat_last [64];
  int            beat_cnt = 0;
  int            done_cnt = 0;
  int            valid_cnt = 0;
  int            ready_cnt = 0;
  logic          busy_at_done = 1'b1;

  always #5 clk_core = ~clk_core;

  hs_npu_result_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
    .clk_core       (clk_core),
    .rst_core_n     (rst_core_n),
    .start          (start),
    .expected_words (expected_words),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .in             (in_word),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .out            (out_beat),
    .lane_mask      (lane_mask),
    .last           (last),
    .busy           (busy),
    .done           (done)
  );

  // Capture handshaken beats and event counts on the inactive edge
  always @(negedge clk_core) begin
    if (rst_core_n) begin
      if (valid_o && ready_i && beat_cnt < 64) begin
        beat_data[beat_cnt] <= out_beat;
        beat_mask[beat_cnt] <= lane_mask;
        beat_last[beat_cnt] <= last;
        beat_cnt <= beat_cnt + 1;
      end
      if (done) begin
        done_cnt     <= done_cnt + 1;
        busy_at_done <= busy;
      end
      if (valid_o) valid_cnt <= valid_cnt + 1;
      if (ready_o) ready_cnt <= ready_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input logic [BW-1:0] data,
                            input logic [3:0] mask, input logic lst);
    check({tag, "_data"}, beat_data[idx], data);
    check({tag, "_mask"}, {124'd0, beat_mask[idx]}, {124'd0, mask});
    check({tag, "_last"}, {127'd0, beat_last[idx]}, {127'd0, lst});
  endtask

  task automatic do_start(input int n);
    @(posedge clk_core); #1;
    start = 1'b1;
    expected_words = uword'(n);
    @(posedge clk_core); #1;
    start = 1'b0;
  endtask

  // Offer words base, base+1, ... until n have been accepted
  task automatic feed(input int n, input logic [31:0] base);
    int   k = 0;
    int   guard = 0;
    logic acc;
    while (k < n && guard < 200) begin
      valid_i = 1'b1;
      in_word = base + 32'(k);
      @(negedge clk_core);
      acc = ready_o;
      @(posedge clk_core); #1;
      if (acc) k++;
      guard++;
    end
    valid_i = 1'b0;
    check("feed_complete", 128'(k), 128'(n));
  endtask

  task automatic wait_done(input int d0, input string tag);
    int g = 0;
    while (done_cnt == d0 && g < 200) begin
      @(posedge clk_core);
      g++;
    end
    repeat (3) @(posedge clk_core);
    #1;
    check({tag, "_done_once"}, 128'(done_cnt - d0), 128'd1);
  endtask

  task automatic stall_watch();
    int            g = 0;
    logic [BW-1:0] snap_data;
    logic [3:0]    snap_mask;
    logic          snap_last;
    while (!valid_o && g < 100) begin
      @(negedge clk_core);
      g++;
    end
    check("bp_beat_appears", {127'd0, valid_o}, 128'd1);
    snap_data = out_beat;
    snap_mask = lane_mask;
    snap_last = last;
    repeat (5) begin
      @(negedge clk_core);
      check("bp_hold_data", out_beat, snap_data);
      check("bp_hold_ctl", {122'd0, valid_o, ready_o, last, lane_mask},
            {122'd0, 1'b1, 1'b0, snap_last, snap_mask});
    end
    @(posedge clk_core); #1;
    ready_i = 1'b1;
  endtask

  initial begin
    int d0;
    int b0;
    int v0;
    int r0;

    #2;
    check("reset_outputs", {121'd0, valid_o, ready_o, last, busy, done, lane_mask[1:0]}, 128'd0);
    check("reset_out_beat", out_beat, 128'd0);
    #18;
    rst_core_n = 1'b1;

    // Full beats: 8 words, two complete beats
    d0 = done_cnt; b0 = beat_cnt;
    ready_i = 1'b1;
    do_start(8);
    check("full_busy_after_start", {127'd0, busy}, 128'd1);
    feed(8, 32'd1);
    wait_done(d0, "full");
    check("full_beats", 128'(beat_cnt - b0), 128'd2);
    check_beat("full_b0", b0,     {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 1'b0);
    check_beat("full_b1", b0 + 1, {32'd8, 32'd7, 32'd6, 32'd5}, 4'hF, 1'b1);
    check("full_busy_at_done", {127'd0, busy_at_done}, 128'd0);

    // Partial tail: 6 words
    d0 = done_cnt; b0 = beat_cnt;
    do_start(6);
    feed(6, 32'hA0);
    wait_done(d0, "part");
    check("part_beats", 128'(beat_cnt - b0), 128'd2);
    check_beat("part_b0", b0,     {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b0);
    check_beat("part_b1", b0 + 1, {32'h0, 32'h0, 32'hA5, 32'hA4}, 4'b0011, 1'b1);

    // Backpressure on the first beat
    d0 = done_cnt; b0 = beat_cnt;
    ready_i = 1'b0;
    do_start(8);
    fork
      feed(8, 32'h10);
      stall_watch();
    join
    wait_done(d0, "bp");
    check("bp_beats", 128'(beat_cnt - b0), 128'd2);
    check_beat("bp_b0", b0,     {32'h13, 32'h12, 32'h11, 32'h10}, 4'hF, 1'b0);
    check_beat("bp_b1", b0 + 1, {32'h17, 32'h16, 32'h15, 32'h14}, 4'hF, 1'b1);

    // Zero-length batch
    d0 = done_cnt; b0 = beat_cnt; v0 = valid_cnt; r0 = ready_cnt;
    valid_i = 1'b1;
    in_word = 32'hDEAD;
    do_start(0);
    wait_done(d0, "zero");
    valid_i = 1'b0;
    check("zero_no_valid", 128'(valid_cnt - v0), 128'd0);
    check("zero_no_ready", 128'(ready_cnt - r0), 128'd0);

    // Start mid-batch is ignored
    d0 = done_cnt; b0 = beat_cnt;
    do_start(5);
    feed(2, 32'h20);
    start = 1'b1;
    expected_words = uword'(3);
    @(posedge clk_core); #1;
    start = 1'b0;
    feed(3, 32'h22);
    wait_done(d0, "ign");
    check("ign_beats", 128'(beat_cnt - b0), 128'd2);
    check_beat("ign_b0", b0,     {32'h23, 32'h22, 32'h21, 32'h20}, 4'hF, 1'b0);
    check_beat("ign_b1", b0 + 1, {32'h0, 32'h0, 32'h0, 32'h24}, 4'b0001, 1'b1);

    // Reset after 2 of 8 words, then a clean 4-word batch
    do_start(8);
    feed(2, 32'h30);
    rst_core_n = 1'b0;
    #1;
    check("rst_mid_ctl", {121'd0, valid_o, ready_o, last, busy, done, lane_mask[1:0]}, 128'd0);
    check("rst_mid_mask_out", {lane_mask, out_beat[123:0]}, 128'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    d0 = done_cnt; b0 = beat_cnt;
    do_start(4);
    feed(4, 32'h40);
    wait_done(d0, "post_rst");
    check("post_rst_beats", 128'(beat_cnt - b0), 128'd1);
    check_beat("post_rst_b0", b0, {32'h43, 32'h42, 32'h41, 32'h40}, 4'hF, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
